data_memory_bank: RTL and testbench

DATA_MEMORY_BANK -- requirements
Module: data_memory_bank

---
 rtl/data_memory_pkg.sv | 35 +++
 rtl/byte_lane_align.sv | 40 ++++
 rtl/data_memory_bank.sv | 119 +++++++++++
 tb/tb_data_memory_bank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared size encodings, FSM state type and latched-request record for the data memory bank.
// The alignment legality check sits here so the bank and any future users apply the same rule.
package data_memory_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_ILL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [1:0]  lane;
    logic [1:0]  size;
    logic        uns;
    logic        is_write;
    logic        fault;
  } req_t;

  // Size/lane combinations the bank refuses: misaligned half/word and the reserved size code.
  function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_HALF: return lane[0];
      SIZE_WORD: return lane != 2'b00;
      SIZE_ILL:  return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Little-endian lane steering: merges store data into the addressed lane(s) and extracts/extends loads.
// Purely combinational; sub-word lane is picked by the two low address bits.
module byte_lane_align
  import data_memory_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_merged,
  output logic [31:0] o_load
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = i_word[{i_lane, 3'b000} +: 8];
    w_half   = i_word[{i_lane[1], 4'b0000} +: 16];
    o_merged = i_word;
    o_load   = '0;
    case (i_size)
      SIZE_BYTE: begin
        o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
        o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      SIZE_HALF: begin
        o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
        o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
      end
      SIZE_WORD: begin
        o_merged = i_wdata;
        o_load   = i_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_bank.sv
// Single-port 32-bit data memory with fixed LATENCY; one access in flight, Ready pulses LATENCY cycles after accept.
// Requests arriving while Busy are dropped rather than queued; illegal accesses complete with Fault and no side effect.
module data_memory_bank
  import data_memory_pkg::*;
#(
  parameter int    DEPTH     = 256,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = "data.mem"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        Fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 4;

  logic [31:0]   r_mem [DEPTH];
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  req_t          r_req;
  req_t          w_in_req;
  req_t          w_cur;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_in_idx;
  logic [AW-1:0] w_cur_idx;
  logic [31:0]   r_rdata;
  logic          w_accept;
  logic          w_wait_done;
  logic          w_enter_resp;
  logic          w_commit;
  logic [31:0]   w_old;
  logic [31:0]   w_merged;
  logic [31:0]   w_load;

  always_comb begin
    w_in_req.wdata    = WriteData;
    w_in_req.lane     = Address[1:0];
    w_in_req.size     = Size;
    w_in_req.uns      = Unsigned;
    w_in_req.is_write = MemWrite;
    w_in_req.fault    = (MemRead & MemWrite)
                      | access_illegal(Size, Address[1:0])
                      | ({2'b00, Address[31:2]} >= 32'(DEPTH));
    w_in_idx          = Address[AW+1:2];
  end

  assign w_accept    = (r_state == ST_IDLE) & (MemRead | MemWrite);
  assign w_wait_done = (32'(r_cnt) + 32'd2) >= 32'(LATENCY);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (w_wait_done) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // With LATENCY=1 the access resolves on the accepting edge, so it must use the live inputs.
  assign w_cur        = (r_state == ST_IDLE) ? w_in_req : r_req;
  assign w_cur_idx    = (r_state == ST_IDLE) ? w_in_idx : r_idx;
  assign w_enter_resp = (w_next == ST_RESP) && (r_state != ST_RESP);
  assign w_commit     = ~reset & w_enter_resp & w_cur.is_write & ~w_cur.fault;
  assign w_old        = r_mem[w_cur_idx];

  byte_lane_align u_align (
    .i_word     (w_old),
    .i_wdata    (w_cur.wdata),
    .i_lane     (w_cur.lane),
    .i_size     (w_cur.size),
    .i_unsigned (w_cur.uns),
    .o_merged   (w_merged),
    .o_load     (w_load)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_req   <= '0;
      r_idx   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_req <= w_in_req;
        r_idx <= w_in_idx;
      end
      r_cnt <= (r_state == ST_WAIT && !w_wait_done) ? r_cnt + CW'(1) : '0;
      if (w_enter_resp) r_rdata <= (w_cur.fault || w_cur.is_write) ? '0 : w_load;
    end
  end

  // Memory array is deliberately outside reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_commit) r_mem[w_cur_idx] <= w_merged;
  end

  assign Busy     = (r_state != ST_IDLE);
  assign Ready    = (r_state == ST_RESP);
  assign Fault    = Ready & r_req.fault;
  assign ReadData = Ready ? r_rdata : '0;

endmodule

// File: tb/tb_data_memory_bank.sv
// Randomized and directed bench for data_memory_bank against a cycle-counting behavioural model.
module tb_data_memory_bank;
  import data_memory_pkg::*;

  localparam int DEPTH   = 16;
  localparam int LATENCY = 2;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] ReadData;
  logic        Ready;
  logic        Busy;
  logic        Fault;

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  data_memory_bank #(.DEPTH(DEPTH), .LATENCY(LATENCY), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .Size(Size), .Unsigned(Unsigned),
    .ReadData(ReadData), .Ready(Ready), .Busy(Busy), .Fault(Fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: m_k counts cycles since the accepting edge (0 = idle).
  logic [31:0] m_mem [DEPTH];
  int          m_k = 0;
  bit          m_rd, m_wr, m_fault, m_un;
  logic [31:0] m_a, m_wd, m_data;
  logic [1:0]  m_sz;

  task automatic model_complete();
    int nb, lane, idx;
    logic [31:0] v, mask;
    m_data = 32'd0;
    if (m_fault) return;
    nb   = 1 << m_sz;
    lane = int'(m_a[1:0]);
    idx  = int'(m_a >> 2);
    if (m_wr) begin
      for (int b = 0; b < nb; b++) m_mem[idx][8*(lane+b) +: 8] = m_wd[8*b +: 8];
    end else begin
      v    = m_mem[idx] >> (8 * lane);
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      v    = v & mask;
      if (!m_un && nb < 4 && v[8*nb-1]) v = v | ~mask;
      m_data = v;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_k = 0;
    end else if (m_k == 0) begin
      if (MemRead || MemWrite) begin
        m_rd = MemRead; m_wr = MemWrite; m_a = Address; m_wd = WriteData;
        m_sz = Size; m_un = Unsigned;
        m_fault = (MemRead && MemWrite) || (Size == 2'd3) || (Size == 2'd1 && Address[0])
               || (Size == 2'd2 && Address[1:0] != 2'd0) || ((Address >> 2) >= DEPTH);
        m_k = 1;
        if (LATENCY == 1) model_complete();
      end
    end else if (m_k == LATENCY) begin
      m_k = 0;
    end else begin
      m_k++;
      if (m_k == LATENCY) model_complete();
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      bit er;
      er = (m_k == LATENCY);
      cmp("Busy", 32'(Busy), 32'(m_k != 0));
      cmp("Ready", 32'(Ready), 32'(er));
      cmp("Fault", 32'(Fault), 32'(er && m_fault));
      if (!(er && m_wr && !m_fault)) cmp("ReadData", ReadData, er ? m_data : 32'd0);
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input bit un,
                        output logic [31:0] rdat, output bit flt);
    bit got;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Address = a; WriteData = wd; Size = sz; Unsigned = un;
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    Address = $urandom(); WriteData = $urandom(); Size = 2'($urandom_range(0, 3));
    Unsigned = 1'($urandom_range(0, 1));
    got = 0; rdat = 32'd0; flt = 0;
    for (int i = 0; i < 16 && !got; i++) begin
      if (Ready) begin
        got = 1; rdat = ReadData; flt = Fault;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      n_vec++; n_bad++;
      $display("FAIL ready_timeout: got no Ready, expected Ready within 16 cycles (addr %h)", a);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    bit f;
    int nready;
    logic [1:0] fsz [5];
    logic [31:0] fad [5];
    bit fwr [5];
    fsz = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2};
    fad = '{32'd6, 32'd1, 32'd0, 32'(4 * DEPTH), 32'd0};
    fwr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; WriteData = '0;
    Size = 2'd0; Unsigned = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1;
    cmp("rst_busy", 32'(Busy), 32'd0);
    cmp("rst_ready", 32'(Ready), 32'd0);
    cmp("rst_fault", 32'(Fault), 32'd0);
    cmp("rst_rdata", ReadData, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) access(0, 1, 32'(i * 4), $urandom(), SIZE_WORD, 0, d, f);

    access(0, 1, 32'd0, 32'h8000_00F0, SIZE_WORD, 0, d, f);
    access(0, 1, 32'd8, 32'd0, SIZE_WORD, 0, d, f);
    access(1, 0, 32'd0, 32'd0, SIZE_WORD, 0, d, f);
    cmp("word_read", d, 32'h8000_00F0);
    cmp("word_read_fault", 32'(f), 32'd0);
    access(1, 0, 32'd0, 32'd0, SIZE_BYTE, 0, d, f);
    cmp("byte_signed", d, 32'hFFFF_FFF0);
    access(1, 0, 32'd0, 32'd0, SIZE_BYTE, 1, d, f);
    cmp("byte_unsigned", d, 32'h0000_00F0);
    access(1, 0, 32'd2, 32'd0, SIZE_HALF, 0, d, f);
    cmp("half_signed", d, 32'hFFFF_8000);
    access(0, 1, 32'd9, 32'h0000_00AB, SIZE_BYTE, 0, d, f);
    access(1, 0, 32'd8, 32'd0, SIZE_WORD, 0, d, f);
    cmp("byte_store", d, 32'h0000_AB00);

    for (int i = 0; i < 5; i++) begin
      access(1, fwr[i], fad[i], 32'hDEAD_BEEF, fsz[i], 0, d, f);
      cmp("fault_flag", 32'(f), 32'd1);
      cmp("fault_rdata", d, 32'd0);
    end
    access(1, 0, 32'd0, 32'd0, SIZE_WORD, 0, d, f);
    cmp("fault_mem_kept", d, 32'h8000_00F0);

    access(0, 1, 32'd4, 32'hCAFE_0001, SIZE_WORD, 0, d, f);
    @(negedge clk);
    MemWrite = 1'b1; Address = 32'd4; WriteData = 32'h1234_5678; Size = SIZE_WORD;
    @(negedge clk);
    MemWrite = 1'b0; reset = 1'b1;
    @(negedge clk);
    cmp("busy_after_reset", 32'(Busy), 32'd0);
    reset = 1'b0;
    access(1, 0, 32'd4, 32'd0, SIZE_WORD, 0, d, f);
    cmp("reset_no_commit", d, 32'hCAFE_0001);

    access(0, 1, 32'd12, 32'h3333_3333, SIZE_WORD, 0, d, f);
    @(negedge clk);
    MemWrite = 1'b1; Address = 32'd8; WriteData = 32'hAAAA_0002; Size = SIZE_WORD;
    nready = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin Address = 32'd12; WriteData = 32'hBBBB_0003; end
      nready += int'(Ready);
      if (i == 1) MemWrite = 1'b0;
    end
    cmp("busy_one_ready", 32'(nready), 32'd1);
    access(1, 0, 32'd8, 32'd0, SIZE_WORD, 0, d, f);
    cmp("busy_first_write", d, 32'hAAAA_0002);
    access(1, 0, 32'd12, 32'd0, SIZE_WORD, 0, d, f);
    cmp("busy_second_dropped", d, 32'h3333_3333);

    for (int n = 0; n < 400; n++) begin
      int r, s;
      bit rd, wr;
      logic [31:0] a;
      logic [1:0] sz;
      r  = $urandom_range(0, 19);
      rd = (r < 10) || (r == 19);
      wr = (r >= 10);
      s  = $urandom_range(0, 7);
      sz = (s < 2) ? 2'd0 : (s < 4) ? 2'd1 : (s == 6) ? 2'd3 : 2'd2;
      a  = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 4 * DEPTH + 7));
      access(rd, wr, a, $urandom(), sz, 1'($urandom_range(0, 1)), d, f);
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
